// File: rtl/scan_pkg.sv
// Shared definitions for the colour-scan sequencer: sensor geometry, colour codes
// and the scheduler state encoding.
package scan_pkg;

  localparam int NUM_SENSORS = 12;
  localparam int COLOR_W     = 2;
  localparam int SEL_W       = 4;

  localparam logic [COLOR_W-1:0] COLOR_R = 2'd0;
  localparam logic [COLOR_W-1:0] COLOR_G = 2'd1;
  localparam logic [COLOR_W-1:0] COLOR_B = 2'd2;
  localparam logic [COLOR_W-1:0] COLOR_Y = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_WAIT_PERIOD = 3'd1,
    ST_START       = 3'd2,
    ST_SCANNING    = 3'd3,
    ST_EVALUATE    = 3'd4
  } scan_state_e;

endpackage

// File: rtl/scan_color_bank.sv
// Shadow bank of per-sensor colours. Out-of-range sensor indices are dropped; the
// publish port already contains any write landing in the same cycle.
module scan_color_bank #(
  parameter int NUM_SENSORS = 12,
  parameter int COLOR_W     = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wr_en,
  input  logic [scan_pkg::SEL_W-1:0]     wr_idx,
  input  logic [COLOR_W-1:0]             wr_color,
  output logic [NUM_SENSORS*COLOR_W-1:0] pub
);

  localparam int BANK_W = NUM_SENSORS * COLOR_W;

  logic [BANK_W-1:0] bank_q;
  logic [BANK_W-1:0] bank_d;
  logic              in_range;

  always_comb begin
    in_range = (int'(wr_idx) < NUM_SENSORS);
    bank_d   = bank_q;
    if (wr_en && in_range) begin
      bank_d[int'(wr_idx) * COLOR_W +: COLOR_W] = wr_color;
    end
  end

  // Publishing the next-state value gives the bypass for a coincident strobe.
  assign pub = bank_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      bank_q <= '0;
    end else begin
      bank_q <= bank_d;
    end
  end

endmodule

// File: rtl/scan_scheduler.sv
// Colour-scan sequencer: starts selector passes periodically or on request,
// publishes the captured bank atomically, flags solved and watchdogs hung scans.
module scan_scheduler #(
  parameter int NUM_SENSORS = 12,
  parameter int COLOR_W     = 2,
  parameter int SCAN_PERIOD = 50000,
  parameter int TIMEOUT     = 1000000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           scanRequest,
  input  logic                           detectionComplete,
  input  logic [3:0]                     sensorSelect,
  input  logic [COLOR_W-1:0]             colorIn,
  input  logic                           selectorComplete,
  input  logic [NUM_SENSORS*COLOR_W-1:0] targetPattern,
  output logic                           startSelector,
  output logic [NUM_SENSORS*COLOR_W-1:0] colors,
  output logic                           scanDone,
  output logic                           solved,
  output logic                           timeoutError,
  output logic [7:0]                     scanCount
);

  import scan_pkg::*;

  localparam int BANK_W = NUM_SENSORS * COLOR_W;
  localparam int PER_W  = $clog2(SCAN_PERIOD + 1);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(SCAN_PERIOD - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  scan_state_e       state_q,   state_d;
  logic [PER_W-1:0]  period_q,  period_d;
  logic [TMO_W-1:0]  tmo_q,     tmo_d;
  logic              pending_q, pending_d;
  logic [BANK_W-1:0] colors_q,  colors_d;
  logic              solved_q,  solved_d;
  logic              terr_q,    terr_d;
  logic [7:0]        count_q,   count_d;

  logic              start_sel;
  logic              scan_done;
  logic              bank_wr;
  logic [BANK_W-1:0] bank_pub;

  scan_color_bank #(
    .NUM_SENSORS (NUM_SENSORS),
    .COLOR_W     (COLOR_W)
  ) u_bank (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (bank_wr),
    .wr_idx   (sensorSelect),
    .wr_color (colorIn),
    .pub      (bank_pub)
  );

  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    tmo_d     = tmo_q;
    pending_d = pending_q | scanRequest;
    colors_d  = colors_q;
    solved_d  = solved_q;
    terr_d    = terr_q;
    count_d   = count_q;
    start_sel = 1'b0;
    scan_done = 1'b0;
    bank_wr   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        period_d = '0;
        if (pending_q) begin
          state_d = ST_START;
        end else if (enable) begin
          state_d = ST_WAIT_PERIOD;
        end
      end

      ST_WAIT_PERIOD: begin
        period_d = period_q + 1'b1;
        if (pending_q || (period_q == PER_LAST)) begin
          state_d = ST_START;
        end else if (!enable) begin
          state_d = ST_IDLE;
        end
      end

      ST_START: begin
        start_sel = 1'b1;
        tmo_d     = '0;
        // A request landing in this very cycle must still schedule another pass.
        pending_d = scanRequest;
        state_d   = ST_SCANNING;
      end

      ST_SCANNING: begin
        bank_wr = detectionComplete;
        tmo_d   = tmo_q + 1'b1;
        if (selectorComplete) begin
          state_d = ST_EVALUATE;
        end else if (tmo_q == TMO_LAST) begin
          terr_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      ST_EVALUATE: begin
        scan_done = 1'b1;
        colors_d  = bank_pub;
        solved_d  = (bank_pub == targetPattern);
        count_d   = count_q + 1'b1;
        terr_d    = 1'b0;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      period_q  <= '0;
      tmo_q     <= '0;
      pending_q <= 1'b0;
      colors_q  <= '0;
      solved_q  <= 1'b0;
      terr_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      tmo_q     <= tmo_d;
      pending_q <= pending_d;
      colors_q  <= colors_d;
      solved_q  <= solved_d;
      terr_q    <= terr_d;
      count_q   <= count_d;
    end
  end

  assign startSelector = start_sel;
  assign scanDone      = scan_done;
  assign colors        = colors_q;
  assign solved        = solved_q;
  assign timeoutError  = terr_q;
  assign scanCount     = count_q;

endmodule

// File: tb/tb_scan_scheduler.sv
// Randomized scoreboard bench for scan_scheduler with a behavioural selector model.
module tb_scan_scheduler;

  localparam int NS = 12;
  localparam int CW = 2;
  localparam int BW = NS * CW;
  localparam int SP = 40;
  localparam int TO = 300;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          scanRequest;
  logic          detectionComplete;
  logic [3:0]    sensorSelect;
  logic [CW-1:0] colorIn;
  logic          selectorComplete;
  logic [BW-1:0] targetPattern;
  logic          startSelector;
  logic [BW-1:0] colors;
  logic          scanDone;
  logic          solved;
  logic          timeoutError;
  logic [7:0]    scanCount;

  scan_scheduler #(
    .NUM_SENSORS (NS),
    .COLOR_W     (CW),
    .SCAN_PERIOD (SP),
    .TIMEOUT     (TO)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .enable            (enable),
    .scanRequest       (scanRequest),
    .detectionComplete (detectionComplete),
    .sensorSelect      (sensorSelect),
    .colorIn           (colorIn),
    .selectorComplete  (selectorComplete),
    .targetPattern     (targetPattern),
    .startSelector     (startSelector),
    .colors            (colors),
    .scanDone          (scanDone),
    .solved            (solved),
    .timeoutError      (timeoutError),
    .scanCount         (scanCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BW-1:0] colors;
    logic          solved;
    logic [7:0]    count;
  } exp_t;

  int            checks = 0;
  int            errors = 0;
  int            cyc    = 0;
  int            starts = 0;
  exp_t          expq[$];
  exp_t          mon_e;
  logic [CW-1:0] model_shadow [NS];
  logic [BW-1:0] pub_colors;
  logic [7:0]    pub_count;
  logic          done_seen = 1'b0;
  logic          busy      = 1'b0;
  logic          terr_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_range(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) model_shadow[i] = '0;
    pub_colors = '0;
    pub_count  = '0;
    expq.delete();
  endtask

  // Expected publish: the whole shadow bank, compared to the target as a vector.
  task automatic push_expected();
    exp_t          e;
    logic [BW-1:0] v;
    v = '0;
    for (int i = 0; i < NS; i++) v[i*CW +: CW] = model_shadow[i];
    e.colors   = v;
    e.solved   = (v == targetPattern);
    e.count    = pub_count + 8'd1;
    pub_colors = e.colors;
    pub_count  = e.count;
    expq.push_back(e);
  endtask

  // Selector model. pat: 0 = i%4, 1 = i%4 with sensor 5 flipped, 2 = random.
  // finish: 0 = complete after last strobe, 1 = coincident with last strobe,
  //         2 = never complete (wait for timeout), 3 = abandon after 5 strobes.
  task automatic serve(input int pat, input int finish, input bit req_mid, output int waited);
    logic [CW-1:0] c;
    int            t0;
    waited = 0;
    while (!startSelector && waited < 4*SP + 20) begin
      tick();
      waited++;
    end
    chk("start_seen", startSelector, 1);
    if (!startSelector) return;
    t0 = cyc;
    tick();
    for (int i = 0; i < NS; i++) begin
      if (finish == 3 && i == 5) return;
      repeat ($urandom_range(0, 2)) tick();
      if ($urandom_range(0, 3) == 0) begin
        detectionComplete = 1'b1;
        sensorSelect      = 4'($urandom_range(NS, 15));
        colorIn           = CW'($urandom);
        tick();
        detectionComplete = 1'b0;
      end
      case (pat)
        0:       c = CW'(i % 4);
        1:       c = CW'(i % 4) ^ ((i == 5) ? CW'(1) : CW'(0));
        default: c = CW'($urandom);
      endcase
      if (finish == 1 && i == NS-1) c = model_shadow[i] ^ CW'(1);
      if (req_mid && i == 3) scanRequest = 1'b1;
      detectionComplete = 1'b1;
      sensorSelect      = 4'(i);
      colorIn           = c;
      model_shadow[i]   = c;
      if (finish == 1 && i == NS-1) begin
        push_expected();
        selectorComplete = 1'b1;
      end
      tick();
      detectionComplete = 1'b0;
      selectorComplete  = 1'b0;
      scanRequest       = 1'b0;
    end
    if (finish == 0) begin
      repeat ($urandom_range(0, 2)) tick();
      push_expected();
      selectorComplete = 1'b1;
      tick();
      selectorComplete = 1'b0;
    end else if (finish == 2) begin
      while (!timeoutError && (cyc - t0) < TO + 20) tick();
      chk_range("timeout_latency", cyc - t0, TO, TO + 1);
    end
  endtask

  // Monitor: pops the scoreboard one cycle after scanDone, when the bank is visible.
  always @(negedge clk) begin
    if (reset) begin
      done_seen <= 1'b0;
      busy      <= 1'b0;
      terr_prev <= 1'b0;
    end else begin
      if (done_seen) begin
        chk("scoreboard_nonempty", expq.size() > 0, 1);
        if (expq.size() > 0) begin
          mon_e = expq.pop_front();
          chk("colors", colors, mon_e.colors);
          chk("solved", solved, mon_e.solved);
          chk("scanCount", scanCount, mon_e.count);
          chk("timeoutError_cleared", timeoutError, 0);
        end
      end
      if (startSelector) begin
        chk("start_while_busy", busy, 0);
        starts <= starts + 1;
      end
      done_seen <= scanDone;
      terr_prev <= timeoutError;
      busy      <= (selectorComplete || (timeoutError && !terr_prev)) ? 1'b0 :
                   (startSelector ? 1'b1 : busy);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_colors"}, colors, 0);
    chk({tag, "_solved"}, solved, 0);
    chk({tag, "_scanCount"}, scanCount, 0);
    chk({tag, "_timeoutError"}, timeoutError, 0);
    chk({tag, "_startSelector"}, startSelector, 0);
    chk({tag, "_scanDone"}, scanDone, 0);
  endtask

  initial begin
    int w;
    int s0;
    logic [BW-1:0] c_before;
    logic [7:0]    n_before;
    logic [CW-1:0] last_col;

    reset = 1'b1; enable = 1'b0; scanRequest = 1'b0; detectionComplete = 1'b0;
    sensorSelect = '0; colorIn = '0; selectorComplete = 1'b0; targetPattern = '0;
    model_reset();
    repeat (3) tick();
    check_outputs_zero("reset");

    // Scenario 1: periodic scan
    reset  = 1'b0;
    enable = 1'b1;
    serve(0, 0, 1'b0, w);
    chk("s1_period_latency", w, SP + 1);
    repeat (3) tick();
    chk("s1_colors", colors, 24'hE4E4E4);
    chk("s1_count", scanCount, 1);

    // Scenario 2: solved, then sensor 5 flipped
    targetPattern = 24'hE4E4E4;
    serve(0, 0, 1'b0, w);
    repeat (3) tick();
    chk("s2_solved", solved, 1);
    serve(1, 0, 1'b0, w);
    repeat (3) tick();
    chk("s2_unsolved", solved, 0);

    // Scenario 3: manual requests only
    enable = 1'b0;
    repeat (3) tick();
    s0 = starts;
    scanRequest = 1'b1;
    tick();
    scanRequest = 1'b0;
    serve(2, 0, 1'b1, w);
    chk("s3_request_latency", w, 1);
    serve(2, 0, 1'b0, w);
    repeat (3 * SP) tick();
    chk("s3_scan_count", starts - s0, 2);

    // Scenario 4: hung selector
    c_before = pub_colors;
    n_before = pub_count;
    scanRequest = 1'b1;
    tick();
    scanRequest = 1'b0;
    serve(2, 2, 1'b0, w);
    chk("s4_timeoutError", timeoutError, 1);
    chk("s4_colors_kept", colors, c_before);
    chk("s4_count_kept", scanCount, n_before);
    repeat (5) tick();
    scanRequest = 1'b1;
    tick();
    scanRequest = 1'b0;
    serve(0, 0, 1'b0, w);
    repeat (3) tick();
    chk("s4_timeout_cleared", timeoutError, 0);

    // Scenario 5: last strobe coincident with selectorComplete
    scanRequest = 1'b1;
    tick();
    scanRequest = 1'b0;
    serve(2, 1, 1'b0, w);
    repeat (3) tick();
    last_col = model_shadow[NS-1];
    chk("s5_last_sensor", colors[BW-1 -: CW], last_col);

    // Scenario 6: reset mid-scan
    scanRequest = 1'b1;
    tick();
    scanRequest = 1'b0;
    serve(2, 3, 1'b0, w);
    reset = 1'b1;
    tick();
    check_outputs_zero("midscan_reset");
    model_reset();
    tick();
    reset  = 1'b0;
    enable = 1'b1;
    serve(0, 0, 1'b0, w);
    chk("s6_period_latency", w, SP + 1);
    repeat (3) tick();
    chk("s6_colors", colors, 24'hE4E4E4);
    chk("s6_count", scanCount, 1);

    // Random periodic scans with a changing target
    for (int k = 0; k < 4; k++) begin
      targetPattern = (k == 2) ? pub_colors : BW'($urandom);
      serve((k == 2) ? 3 : 2, int'($urandom_range(0, 1)), 1'b0, w);
      repeat (3) tick();
    end
    enable = 1'b0;
    repeat (SP) tick();
    chk("scoreboard_drained", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
